// File: rtl/frame_rx_if.sv
// Bundles the serial line inputs, consumer handshake and status outputs of the
// frame receiver. The master side drives the line and the acknowledge, and the
// slave side is the receiver itself.
interface frame_rx_if;
  logic       SERIAL_CLOCK;
  logic       SERIAL_DATA;
  logic       ENABLE;
  logic       FRAME_ACK;
  logic       SHIFT_ENABLE;
  logic [3:0] BIT_COUNT;
  logic       BUSY;
  logic [7:0] FRAME_DATA;
  logic       FRAME_VALID;
  logic       FRAME_ERROR;
  logic [1:0] ERROR_CODE;
  logic       OVERRUN;

  modport master (
    output SERIAL_CLOCK, SERIAL_DATA, ENABLE, FRAME_ACK,
    input  SHIFT_ENABLE, BIT_COUNT, BUSY, FRAME_DATA, FRAME_VALID,
           FRAME_ERROR, ERROR_CODE, OVERRUN
  );

  modport slave (
    input  SERIAL_CLOCK, SERIAL_DATA, ENABLE, FRAME_ACK,
    output SHIFT_ENABLE, BIT_COUNT, BUSY, FRAME_DATA, FRAME_VALID,
           FRAME_ERROR, ERROR_CODE, OVERRUN
  );
endinterface

// File: rtl/frame_rx_controller.sv
// Receives 11-bit serial frames (start, 8 data bits LSB first, odd parity,
// stop) from a debounced line clock/data pair that is sampled in the FCLK
// domain. It verifies each frame, aborts a stalled frame after a timeout, and
// hands good bytes to the consumer through a VALID/ACK hold handshake.
module frame_rx_controller #(
  parameter int FRAME_BITS     = 11,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int TIMEOUT_W      = 12
) (
  input logic      FCLK,
  input logic      RESET,
  frame_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t                  state;
  logic                    clkQ;
  logic                    fall;
  logic [FRAME_BITS-1:0]   shiftReg;
  logic [TIMEOUT_W-1:0]    timeoutCount;
  logic                    stopBad;
  logic                    parityBad;

  // A falling line clock is seen when the previous sample was high and the
  // current one is low; the line data is taken in that same cycle.
  assign fall = clkQ & ~bus.SERIAL_CLOCK;

  // Frame verdicts evaluated on the fully shifted frame while in CHECK. A
  // non-zero start bit is lumped in with a bad stop bit as a framing fault.
  assign stopBad   = ~shiftReg[FRAME_BITS-1] | shiftReg[0];
  assign parityBad = ~(^shiftReg[FRAME_BITS-2:1]);

  // Single sequencer: edge history, bit shifting, timeout, frame checking and
  // the output handshake, with every output registered.
  always_ff @(posedge FCLK) begin
    if (RESET) begin
      state            <= IDLE;
      clkQ             <= 1'b1;
      shiftReg         <= '0;
      timeoutCount     <= '0;
      bus.SHIFT_ENABLE <= 1'b0;
      bus.BIT_COUNT    <= 4'd0;
      bus.BUSY         <= 1'b0;
      bus.FRAME_DATA   <= 8'd0;
      bus.FRAME_VALID  <= 1'b0;
      bus.FRAME_ERROR  <= 1'b0;
      bus.ERROR_CODE   <= 2'b00;
      bus.OVERRUN      <= 1'b0;
    end else begin
      clkQ             <= bus.SERIAL_CLOCK;
      bus.SHIFT_ENABLE <= 1'b0;
      bus.FRAME_ERROR  <= 1'b0;
      bus.OVERRUN      <= 1'b0;

      if (bus.FRAME_ACK && bus.FRAME_VALID) begin
        bus.FRAME_VALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.ENABLE && fall && !bus.SERIAL_DATA) begin
            state            <= RECEIVE;
            shiftReg         <= {bus.SERIAL_DATA, shiftReg[FRAME_BITS-1:1]};
            bus.BIT_COUNT    <= 4'd1;
            bus.SHIFT_ENABLE <= 1'b1;
            bus.BUSY         <= 1'b1;
            timeoutCount     <= '0;
          end
        end

        RECEIVE: begin
          if (!bus.ENABLE) begin
            state         <= IDLE;
            bus.BIT_COUNT <= 4'd0;
            bus.BUSY      <= 1'b0;
          end else if (fall) begin
            shiftReg         <= {bus.SERIAL_DATA, shiftReg[FRAME_BITS-1:1]};
            bus.BIT_COUNT    <= bus.BIT_COUNT + 4'd1;
            bus.SHIFT_ENABLE <= 1'b1;
            timeoutCount     <= '0;
            if (bus.BIT_COUNT == 4'(FRAME_BITS - 1)) begin
              state <= CHECK;
            end
          end else if (timeoutCount == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state           <= IDLE;
            bus.BIT_COUNT   <= 4'd0;
            bus.BUSY        <= 1'b0;
            bus.FRAME_ERROR <= 1'b1;
            bus.ERROR_CODE  <= 2'b11;
          end else begin
            timeoutCount <= timeoutCount + 1'b1;
          end
        end

        CHECK: begin
          state         <= IDLE;
          bus.BIT_COUNT <= 4'd0;
          bus.BUSY      <= 1'b0;
          if (bus.ENABLE) begin
            if (stopBad) begin
              bus.FRAME_ERROR <= 1'b1;
              bus.ERROR_CODE  <= 2'b10;
            end else if (parityBad) begin
              bus.FRAME_ERROR <= 1'b1;
              bus.ERROR_CODE  <= 2'b01;
            end else if (bus.FRAME_VALID && !bus.FRAME_ACK) begin
              bus.OVERRUN <= 1'b1;
            end else begin
              bus.FRAME_DATA  <= shiftReg[8:1];
              bus.FRAME_VALID <= 1'b1;
            end
          end
        end

        default: begin
          state         <= IDLE;
          bus.BIT_COUNT <= 4'd0;
          bus.BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_rx_controller.sv
// Directed and randomized frames driven through the serial line, with every
// outcome predicted by a frame-level reference model of the receiver.
module tb_frame_rx_controller;
  localparam int HALF     = 4;
  localparam int TIMEOUT  = 2000;

  logic FCLK = 1'b0;
  logic RESET;

  frame_rx_if bus ();

  frame_rx_controller #(
    .FRAME_BITS(11),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TIMEOUT_W(12)
  ) dut (
    .FCLK(FCLK),
    .RESET(RESET),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int shiftSeen   = 0;
  int errSeen     = 0;
  int overrunSeen = 0;

  logic       modelValid;
  logic [7:0] modelData;
  logic [1:0] modelErr;

  // Free-running fast clock.
  always #5 FCLK = ~FCLK;

  // Counts one-cycle strobes, sampled away from the active edge.
  always @(negedge FCLK) begin
    if (bus.SHIFT_ENABLE === 1'b1) shiftSeen++;
    if (bus.FRAME_ERROR === 1'b1) errSeen++;
    if (bus.OVERRUN === 1'b1) overrunSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Frame with odd parity over data+parity, optionally corrupted.
  function automatic logic [10:0] buildFrame(input logic [7:0] d,
                                             input logic badParity,
                                             input logic stopBit);
    logic par;
    par = ~(^d) ^ badParity;
    return {stopBit, par, d, 1'b0};
  endfunction

  // 0 good, 1 parity, 2 framing; framing wins over parity.
  function automatic int frameVerdict(input logic [10:0] f);
    if (f[10] == 1'b0) return 2;
    if (($countones(f[9:1]) % 2) == 0) return 1;
    return 0;
  endfunction

  // Drives n bits of a frame, each with HALF cycles high then HALF low.
  task automatic sendBits(input logic [10:0] f, input int n, input bit ackOnCheck);
    for (int i = 0; i < n; i++) begin
      @(negedge FCLK);
      bus.SERIAL_DATA = f[i];
      repeat (HALF - 1) @(negedge FCLK);
      bus.SERIAL_CLOCK = 1'b0;
      if (ackOnCheck && i == n - 1) begin
        @(negedge FCLK);
        bus.FRAME_ACK = 1'b1;
        @(negedge FCLK);
        bus.FRAME_ACK = 1'b0;
        repeat (HALF - 2) @(negedge FCLK);
      end else begin
        repeat (HALF) @(negedge FCLK);
      end
      bus.SERIAL_CLOCK = 1'b1;
    end
  endtask

  task automatic ackFrame();
    @(negedge FCLK);
    bus.FRAME_ACK = 1'b1;
    @(negedge FCLK);
    bus.FRAME_ACK = 1'b0;
    modelValid = 1'b0;
    checkOutput("ack_valid", 32'(bus.FRAME_VALID), 32'(modelValid));
  endtask

  task automatic applyReset();
    @(negedge FCLK);
    RESET = 1'b1;
    repeat (2) @(negedge FCLK);
    RESET = 1'b0;
    modelValid = 1'b0;
    modelData  = 8'h00;
    modelErr   = 2'b00;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    checkOutput({tag, "_bitcount"}, 32'(bus.BIT_COUNT), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.FRAME_VALID), 32'(modelValid));
    checkOutput({tag, "_data"}, 32'(bus.FRAME_DATA), 32'(modelData));
    checkOutput({tag, "_errcode"}, 32'(bus.ERROR_CODE), 32'(modelErr));
  endtask

  // Sends a complete frame and checks every consequence against the model.
  task automatic applyStimulus(input string tag, input logic [7:0] d,
                               input logic badParity, input logic stopBit,
                               input bit ackOnCheck);
    logic [10:0] f;
    int verdict, s0, e0, o0;
    bit expOverrun;
    f = buildFrame(d, badParity, stopBit);
    verdict = frameVerdict(f);
    s0 = shiftSeen; e0 = errSeen; o0 = overrunSeen;
    expOverrun = 1'b0;
    if (verdict == 0) begin
      if (modelValid && !ackOnCheck) expOverrun = 1'b1;
      else begin
        modelData  = d;
        modelValid = 1'b1;
      end
    end else begin
      modelErr = 2'(verdict);
      if (ackOnCheck) modelValid = 1'b0;
    end
    sendBits(f, 11, ackOnCheck);
    repeat (3) @(negedge FCLK);
    checkOutput({tag, "_shifts"}, 32'(shiftSeen - s0), 32'd11);
    checkOutput({tag, "_errpulse"}, 32'(errSeen - e0), 32'(verdict != 0));
    checkOutput({tag, "_overrun"}, 32'(overrunSeen - o0), 32'(expOverrun));
    checkIdleOutputs(tag);
  endtask

  initial begin
    int e0, elapsed;
    bit seen;
    RESET            = 1'b1;
    bus.SERIAL_CLOCK = 1'b1;
    bus.SERIAL_DATA  = 1'b1;
    bus.ENABLE       = 1'b1;
    bus.FRAME_ACK    = 1'b0;
    applyReset();
    checkIdleOutputs("reset");
    checkOutput("reset_shift", 32'(bus.SHIFT_ENABLE), 32'd0);
    checkOutput("reset_err", 32'(bus.FRAME_ERROR), 32'd0);
    checkOutput("reset_ovr", 32'(bus.OVERRUN), 32'd0);

    applyStimulus("clean1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    ackFrame();
    applyStimulus("parity1c", 8'h1C, 1'b1, 1'b1, 1'b0);
    applyStimulus("stop0", 8'h1C, 1'b1, 1'b0, 1'b0);

    // A start bit of 1 must be ignored.
    e0 = errSeen;
    sendBits(11'h7FF, 1, 1'b0);
    repeat (2) @(negedge FCLK);
    checkOutput("falsestart_busy", 32'(bus.BUSY), 32'd0);
    checkOutput("falsestart_err", 32'(errSeen - e0), 32'd0);

    // Stall after 5 bits until the timeout fires.
    e0 = errSeen;
    sendBits(buildFrame(8'hA5, 1'b0, 1'b1), 5, 1'b0);
    checkOutput("to_bitcount5", 32'(bus.BIT_COUNT), 32'd5);
    checkOutput("to_busy", 32'(bus.BUSY), 32'd1);
    elapsed = HALF;
    seen = 1'b0;
    while (!seen && elapsed < TIMEOUT + 50) begin
      @(negedge FCLK);
      elapsed++;
      if (bus.FRAME_ERROR === 1'b1) seen = 1'b1;
    end
    checkOutput("to_fired", 32'(seen), 32'd1);
    checkOutput("to_latency_window",
                32'(elapsed >= TIMEOUT && elapsed <= TIMEOUT + 1), 32'd1);
    modelErr = 2'b11;
    @(negedge FCLK);
    checkOutput("to_errcount", 32'(errSeen - e0), 32'd1);
    checkIdleOutputs("to");
    applyStimulus("after_to", 8'h3C, 1'b0, 1'b1, 1'b0);
    ackFrame();

    // Overrun, then a good frame coincident with ACK.
    applyStimulus("ovr_a", 8'h1C, 1'b0, 1'b1, 1'b0);
    applyStimulus("ovr_b", 8'h32, 1'b0, 1'b1, 1'b0);
    ackFrame();
    applyStimulus("coack_a", 8'h1C, 1'b0, 1'b1, 1'b0);
    applyStimulus("coack_b", 8'h32, 1'b0, 1'b1, 1'b1);
    ackFrame();

    // Reset part way through a frame.
    e0 = errSeen;
    sendBits(buildFrame(8'h77, 1'b0, 1'b1), 6, 1'b0);
    checkOutput("rst_bitcount6", 32'(bus.BIT_COUNT), 32'd6);
    applyReset();
    checkIdleOutputs("midrst");
    checkOutput("midrst_err", 32'(errSeen - e0), 32'd0);
    applyStimulus("after_rst", 8'h5A, 1'b0, 1'b1, 1'b0);
    ackFrame();

    // ENABLE dropped mid-frame discards silently.
    e0 = errSeen;
    sendBits(buildFrame(8'hC3, 1'b0, 1'b1), 4, 1'b0);
    @(negedge FCLK);
    bus.ENABLE = 1'b0;
    repeat (2) @(negedge FCLK);
    checkIdleOutputs("disable");
    checkOutput("disable_err", 32'(errSeen - e0), 32'd0);
    bus.ENABLE = 1'b1;

    // Randomized frames with random corruption and acknowledgement.
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      int kind;
      d = 8'($urandom);
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) ackFrame();
      case (kind)
        2:       applyStimulus("rnd_par", d, 1'b1, 1'b1, 1'b0);
        3:       applyStimulus("rnd_stop", d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        default: applyStimulus("rnd_good", d, 1'b0, 1'b1, ($urandom_range(0, 3) == 0));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
